revaluate_batch_scheduler: RTL and testbench
============================================

# revaluate_batch_scheduler

Multi-block, multi-round sequencer for the revaluate datapath. It takes one `start` command with a block count, then for each block it:
- loads the block from the file interface,
- runs NUM_ROUNDS rounds, each a fixed NUM_STAGES-step chain of stage-engine start/done handshakes,
- writes the result back.

A watchdog converts a hung handshake into a sticky error. It sits between the testbench/file layer and the stage engines, replacing single-shot top-level sequencing.

## Interface
- NUM_ROUNDS, 24, rounds per block (≥1)
- NUM_STAGES, 4, stage steps per round (≥1); stage_sel counts 0..NUM_STAGES-1
- BLK_W, 8, width of block count/index
- TIMEOUT, 255, max cycles waiting on any `*_done`/`*_ack`/`*_ready` before error
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin batch; honoured only in IDLE or ERR
- num_blocks  in  BLK_W  block count, sampled on accepted start
- read_file  out  1  one-cycle pulse: load block blk_idx
- read_ready  in  1  block loaded into datapath
- stage_start  out  1  one-cycle pulse: run step stage_sel of round round_idx
- stage_sel  out  clog2(NUM_STAGES)  current step
- round_idx  out  clog2(NUM_ROUNDS)  current round (round-constant index)
- stage_done  in  1  stage engine finished
- write_file  out  1  one-cycle pulse: store block blk_idx
- write_ack  in  1  store complete
- blk_idx  out  BLK_W  current block index
- busy  out  1  high in every state except IDLE/ERR
- finish  out  1  one-cycle pulse at batch completion
- err  out  1  sticky; cleared only by accepted start or reset

## Operation
- States: IDLE, LOAD, WAIT_RD, ISSUE, WAIT_ST, STORE, WAIT_WR, NEXT, DONE, ERR. State is registered; outputs are decoded from present state, except the counters, which are registers.
- IDLE: start → LOAD, latch num_blocks, clear blk_idx/round_idx/stage_sel/err. If num_blocks==0 → DONE directly.
- LOAD: read_file=1 → WAIT_RD.
- WAIT_RD: read_ready → ISSUE.
- ISSUE: stage_start=1 → WAIT_ST.
- WAIT_ST: stage_done advances the counters and the state:
  - stage_sel<NUM_STAGES-1: stage_sel++ → ISSUE.
  - Otherwise stage_sel←0. If round_idx<NUM_ROUNDS-1: round_idx++ → ISSUE. Else → STORE.
- STORE: write_file=1 → WAIT_WR.
- WAIT_WR: write_ack → NEXT.
- NEXT: if blk_idx==num_blocks-1 → DONE. Else blk_idx++, round_idx←0 → LOAD.
- DONE: finish=1 → IDLE.
- Watchdog counter:
  - Clears on entry to WAIT_RD/WAIT_ST/WAIT_WR; increments while in those states.
  - Reaching TIMEOUT without the awaited input → ERR, err←1.
  - An awaited input arriving in the same cycle as count==TIMEOUT wins: no error.
- ERR: busy=0, no pulses. start → LOAD as from IDLE, err cleared.
- Inputs are ignored outside their wait state, including stray stage_done, read_ready and write_ack. start is ignored while busy.
- Reset (any time, including mid-batch):
  - State → IDLE, all counters 0.
  - Outputs: read_file, stage_start, write_file, finish, busy and err all 0; blk_idx, round_idx and stage_sel all 0.

## Timing
- Accepted start at edge k: read_file high in cycle k+1.
- Each awaited input is registered at the edge where it is seen. The next pulse appears 1 cycle later (read_ready seen at edge m → stage_start high in cycle m+1).
- stage_sel/round_idx are stable and valid during the stage_start cycle and throughout WAIT_ST.
- blk_idx is stable from LOAD through NEXT.
- With zero-latency responders (done asserted the cycle after each pulse), per-block latency = 4 + 2·NUM_ROUNDS·NUM_STAGES + 1 cycles; batch adds 1 cycle (DONE).
- Minimum start-to-finish for num_blocks=0: start edge k, finish high cycle k+1.

## Structure
- Shared package `revaluate_pkg`: state encoding constants (3-bit, the 10 states need 4 bits → use 4-bit `REV_STATE_W`), default NUM_ROUNDS/NUM_STAGES/TIMEOUT.
- One natural sub-module: `revaluate_watchdog` (clear, enable, TIMEOUT parameter → expired). Everything else stays in the FSM module.

## Test plan
- Reset mid-WAIT_ST (round 5, stage 2) → all outputs 0 at once, asynchronously; later start runs a clean batch from blk_idx 0.
- num_blocks=1, NUM_ROUNDS=2, NUM_STAGES=2, immediate responders → read_file 1×, stage_start 4× with (round,stage) = (0,0),(0,1),(1,0),(1,1), write_file 1×, finish 1×.
- num_blocks=3, default params → exactly 3 read/write pulse pairs with blk_idx 0,1,2 and 96 stage_start per block; finish once, busy low afterwards.
- num_blocks=0 → finish the cycle after start; no read_file, stage_start or write_file.
- stage_done withheld 255 cycles → err=1, busy=0 in ERR. Stage_done on exactly cycle 255 → no error. A new start clears err.
- Stray stage_done in IDLE/WAIT_RD and start while busy → no state or counter change.

Source files
------------

// File: rtl/revaluate_pkg.sv
// Shared definitions for the revaluate batch sequencer: state encoding,
// default sizing and a width helper for small index counters.
package revaluate_pkg;

    localparam int REV_STATE_W     = 4;
    localparam int DEF_NUM_ROUNDS  = 24;
    localparam int DEF_NUM_STAGES  = 4;
    localparam int DEF_BLK_W       = 8;
    localparam int DEF_TIMEOUT     = 255;

    typedef enum logic [REV_STATE_W-1:0] {
        ST_IDLE    = 4'd0,
        ST_LOAD    = 4'd1,
        ST_WAIT_RD = 4'd2,
        ST_ISSUE   = 4'd3,
        ST_WAIT_ST = 4'd4,
        ST_STORE   = 4'd5,
        ST_WAIT_WR = 4'd6,
        ST_NEXT    = 4'd7,
        ST_DONE    = 4'd8,
        ST_ERR     = 4'd9
    } rev_state_e;

    // A counter over n values still needs one bit when n is 1.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/revaluate_watchdog.sv
// Cycle counter that flags a handshake which has waited TIMEOUT cycles.
// Saturates at TIMEOUT so a long stall cannot wrap back to a safe value.
module revaluate_watchdog
    import revaluate_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/revaluate_batch_scheduler.sv
// Sequences load / NUM_ROUNDS x NUM_STAGES stage handshakes / store for each
// block of a batch, with a watchdog turning a hung handshake into sticky err.
module revaluate_batch_scheduler
    import revaluate_pkg::*;
#(
    parameter  int NUM_ROUNDS = DEF_NUM_ROUNDS,
    parameter  int NUM_STAGES = DEF_NUM_STAGES,
    parameter  int BLK_W      = DEF_BLK_W,
    parameter  int TIMEOUT    = DEF_TIMEOUT,
    localparam int SEL_W      = idx_width(NUM_STAGES),
    localparam int RND_W      = idx_width(NUM_ROUNDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BLK_W-1:0] num_blocks,
    output logic             read_file,
    input  logic             read_ready,
    output logic             stage_start,
    output logic [SEL_W-1:0] stage_sel,
    output logic [RND_W-1:0] round_idx,
    input  logic             stage_done,
    output logic             write_file,
    input  logic             write_ack,
    output logic [BLK_W-1:0] blk_idx,
    output logic             busy,
    output logic             finish,
    output logic             err
);

    localparam logic [SEL_W-1:0] LAST_STAGE = SEL_W'(NUM_STAGES - 1);
    localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(NUM_ROUNDS - 1);

    rev_state_e       state;
    rev_state_e       state_next;
    logic [BLK_W-1:0] num_blocks_q;
    logic [BLK_W-1:0] last_blk;
    logic             wd_clear;
    logic             wd_enable;
    logic             wd_expired;
    logic             enter_err;
    logic             accept_start;

    assign last_blk     = num_blocks_q - 1'b1;
    assign accept_start = start && ((state == ST_IDLE) || (state == ST_ERR));

    // Every wait state is entered from exactly one pulse state, so clearing
    // there guarantees a fresh count on the first waiting cycle.
    assign wd_clear  = (state == ST_LOAD) || (state == ST_ISSUE) || (state == ST_STORE);
    assign wd_enable = (state == ST_WAIT_RD) || (state == ST_WAIT_ST) || (state == ST_WAIT_WR);

    revaluate_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        enter_err   = 1'b0;
        read_file   = 1'b0;
        stage_start = 1'b0;
        write_file  = 1'b0;
        finish      = 1'b0;
        busy        = 1'b1;
        case (state)
            ST_IDLE, ST_ERR: begin
                busy = 1'b0;
                if (start) begin
                    state_next = (num_blocks == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                read_file  = 1'b1;
                state_next = ST_WAIT_RD;
            end
            ST_WAIT_RD: begin
                if (read_ready) begin
                    state_next = ST_ISSUE;
                end else if (wd_expired) begin
                    enter_err = 1'b1;
                end
            end
            ST_ISSUE: begin
                stage_start = 1'b1;
                state_next  = ST_WAIT_ST;
            end
            ST_WAIT_ST: begin
                if (stage_done) begin
                    if ((stage_sel == LAST_STAGE) && (round_idx == LAST_ROUND)) begin
                        state_next = ST_STORE;
                    end else begin
                        state_next = ST_ISSUE;
                    end
                end else if (wd_expired) begin
                    enter_err = 1'b1;
                end
            end
            ST_STORE: begin
                write_file = 1'b1;
                state_next = ST_WAIT_WR;
            end
            ST_WAIT_WR: begin
                if (write_ack) begin
                    state_next = ST_NEXT;
                end else if (wd_expired) begin
                    enter_err = 1'b1;
                end
            end
            ST_NEXT: begin
                state_next = (blk_idx == last_blk) ? ST_DONE : ST_LOAD;
            end
            ST_DONE: begin
                finish     = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
        if (enter_err) begin
            state_next = ST_ERR;
        end
    end

    // Stage and round counters only move on a real stage_done in WAIT_ST;
    // stray handshakes elsewhere leave every index untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            num_blocks_q <= '0;
            blk_idx      <= '0;
            round_idx    <= '0;
            stage_sel    <= '0;
            err          <= 1'b0;
        end else begin
            if (accept_start) begin
                num_blocks_q <= num_blocks;
                blk_idx      <= '0;
                round_idx    <= '0;
                stage_sel    <= '0;
                err          <= 1'b0;
            end
            if (enter_err) begin
                err <= 1'b1;
            end
            if ((state == ST_WAIT_ST) && stage_done) begin
                if (stage_sel == LAST_STAGE) begin
                    stage_sel <= '0;
                    if (round_idx != LAST_ROUND) begin
                        round_idx <= round_idx + 1'b1;
                    end
                end else begin
                    stage_sel <= stage_sel + 1'b1;
                end
            end
            if ((state == ST_NEXT) && (blk_idx != last_blk)) begin
                blk_idx   <= blk_idx + 1'b1;
                round_idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_revaluate_batch_scheduler.sv
// Directed bench for revaluate_batch_scheduler: a default-sized instance and a
// 2x2 instance, driven by delayed responders and checked against a pulse model.
module tb_revaluate_batch_scheduler;
    import revaluate_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       start_a = 1'b0;
    logic [7:0] num_blocks_a = 8'd0;
    logic       read_ready_a, stage_done_a, write_ack_a;
    logic       read_file_a, stage_start_a, write_file_a, busy_a, finish_a, err_a;
    logic [1:0] stage_sel_a;
    logic [4:0] round_idx_a;
    logic [7:0] blk_idx_a;

    logic       start_b = 1'b0;
    logic [7:0] num_blocks_b = 8'd0;
    logic       read_ready_b, stage_done_b, write_ack_b;
    logic       read_file_b, stage_start_b, write_file_b, busy_b, finish_b, err_b;
    logic [0:0] stage_sel_b;
    logic [0:0] round_idx_b;
    logic [7:0] blk_idx_b;

    revaluate_batch_scheduler dut_a (
        .clk(clk), .rst(rst), .start(start_a), .num_blocks(num_blocks_a),
        .read_file(read_file_a), .read_ready(read_ready_a),
        .stage_start(stage_start_a), .stage_sel(stage_sel_a), .round_idx(round_idx_a),
        .stage_done(stage_done_a), .write_file(write_file_a), .write_ack(write_ack_a),
        .blk_idx(blk_idx_a), .busy(busy_a), .finish(finish_a), .err(err_a)
    );

    revaluate_batch_scheduler #(.NUM_ROUNDS(2), .NUM_STAGES(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .num_blocks(num_blocks_b),
        .read_file(read_file_b), .read_ready(read_ready_b),
        .stage_start(stage_start_b), .stage_sel(stage_sel_b), .round_idx(round_idx_b),
        .stage_done(stage_done_b), .write_file(write_file_b), .write_ack(write_ack_b),
        .blk_idx(blk_idx_b), .busy(busy_b), .finish(finish_b), .err(err_b)
    );

    // Responders answer one cycle after each pulse; manual overrides inject handshakes.
    logic auto_rd = 1'b1, auto_st = 1'b1, auto_wr = 1'b1;
    logic man_rd = 1'b0, man_st = 1'b0, man_wr = 1'b0;
    logic rd_pend_a = 1'b0, st_pend_a = 1'b0, wr_pend_a = 1'b0;
    logic rd_pend_b = 1'b0, st_pend_b = 1'b0, wr_pend_b = 1'b0;

    always @(posedge clk) begin
        rd_pend_a <= read_file_a;
        st_pend_a <= stage_start_a;
        wr_pend_a <= write_file_a;
        rd_pend_b <= read_file_b;
        st_pend_b <= stage_start_b;
        wr_pend_b <= write_file_b;
    end

    assign read_ready_a = (auto_rd & rd_pend_a) | man_rd;
    assign stage_done_a = (auto_st & st_pend_a) | man_st;
    assign write_ack_a  = (auto_wr & wr_pend_a) | man_wr;
    assign read_ready_b = auto_rd & rd_pend_b;
    assign stage_done_b = auto_st & st_pend_b;
    assign write_ack_b  = auto_wr & wr_pend_b;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor with an independent model of the expected index sequence.
    int sel = 0;
    int rd_cnt, st_cnt, wr_cnt, fin_cnt, fin_cyc, seq_err;
    int exp_blk, mr, ms;

    always @(negedge clk) begin
        int r_n, s_n, blk, rnd, stg;
        logic rf, ss, wf, fn;
        r_n = (sel == 1) ? 2 : 24;
        s_n = (sel == 1) ? 2 : 4;
        rf  = (sel == 1) ? read_file_b : read_file_a;
        ss  = (sel == 1) ? stage_start_b : stage_start_a;
        wf  = (sel == 1) ? write_file_b : write_file_a;
        fn  = (sel == 1) ? finish_b : finish_a;
        blk = (sel == 1) ? int'(blk_idx_b) : int'(blk_idx_a);
        rnd = (sel == 1) ? int'(round_idx_b) : int'(round_idx_a);
        stg = (sel == 1) ? int'(stage_sel_b) : int'(stage_sel_a);
        if (rf) begin
            rd_cnt++;
            if (blk != exp_blk) seq_err++;
            mr = 0;
            ms = 0;
        end
        if (ss) begin
            st_cnt++;
            if ((rnd != mr) || (stg != ms)) seq_err++;
            if (ms == s_n - 1) begin
                ms = 0;
                mr = (mr == r_n - 1) ? 0 : mr + 1;
            end else begin
                ms++;
            end
        end
        if (wf) begin
            wr_cnt++;
            if (blk != exp_blk) seq_err++;
            exp_blk++;
        end
        if (fn) begin
            fin_cnt++;
            fin_cyc = cyc;
        end
    end

    int checks = 0;
    int errors = 0;
    int start_cyc = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic clearMon(input int which);
        sel     = which;
        rd_cnt  = 0;
        st_cnt  = 0;
        wr_cnt  = 0;
        fin_cnt = 0;
        fin_cyc = 0;
        seq_err = 0;
        exp_blk = 0;
        mr      = 0;
        ms      = 0;
    endtask

    // Leaves the bench at the negedge in the cycle after the accepting edge.
    task automatic doStart(input int which, input int n);
        @(negedge clk); #1;
        if (which == 1) begin
            start_b = 1'b1; num_blocks_b = 8'(n);
        end else begin
            start_a = 1'b1; num_blocks_a = 8'(n);
        end
        @(negedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic waitFinish(input int budget, input string name);
        int ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (fin_cnt > 0) begin
                ok = 1;
                break;
            end
            @(negedge clk); #1;
        end
        checkOutput({name, "_finished"}, ok, 1);
    endtask

    task automatic applyStimulus(input int which, input int n, input int budget, input string name);
        clearMon(which);
        doStart(which, n);
        waitFinish(budget, name);
    endtask

    typedef struct {
        string name;
        int    which;
        int    n;
        int    exp_reads;
        int    exp_stages;
        int    exp_lat;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int   x_ok;
        logic pulses;

        vecs[0] = '{"small_n1",   1, 1, 1,   4,  13};
        vecs[1] = '{"default_n3", 0, 3, 3, 288, 591};
        vecs[2] = '{"default_n0", 0, 0, 0,   0,   0};
        vecs[3] = '{"small_n2",   1, 2, 2,   8,  26};
        vecs[4] = '{"default_n1", 0, 1, 1,  96, 197};

        @(negedge clk); #1;
        pulses = read_file_a | stage_start_a | write_file_a | finish_a | busy_a | err_a;
        checkOutput("reset_pulses_a", int'(pulses), 0);
        checkOutput("reset_idx_a", int'(blk_idx_a) + int'(round_idx_a) + int'(stage_sel_a), 0);
        checkOutput("reset_busy_b", int'(busy_b | err_b), 0);
        @(negedge clk); #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;

        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].which, vecs[v].n, vecs[v].exp_lat + 50, vecs[v].name);
            checkOutput({vecs[v].name, "_reads"}, rd_cnt, vecs[v].exp_reads);
            checkOutput({vecs[v].name, "_writes"}, wr_cnt, vecs[v].exp_reads);
            checkOutput({vecs[v].name, "_stages"}, st_cnt, vecs[v].exp_stages);
            checkOutput({vecs[v].name, "_finishes"}, fin_cnt, 1);
            checkOutput({vecs[v].name, "_latency"}, fin_cyc - start_cyc, vecs[v].exp_lat);
            checkOutput({vecs[v].name, "_sequence"}, seq_err, 0);
            @(negedge clk); #1;
            checkOutput({vecs[v].name, "_busy_after"},
                        int'((vecs[v].which == 1) ? busy_b : busy_a), 0);
            checkOutput({vecs[v].name, "_err_after"},
                        int'((vecs[v].which == 1) ? err_b : err_a), 0);
        end

        // Stray handshakes in IDLE and WAIT_RD, plus start while busy.
        clearMon(0);
        auto_rd = 1'b0; auto_st = 1'b0; auto_wr = 1'b0;
        man_rd = 1'b1; man_st = 1'b1; man_wr = 1'b1;
        @(negedge clk); #1;
        man_rd = 1'b0; man_st = 1'b0; man_wr = 1'b0;
        @(negedge clk); #1;
        checkOutput("stray_idle_busy", int'(busy_a), 0);
        checkOutput("stray_idle_pulses", rd_cnt + st_cnt + wr_cnt, 0);
        doStart(0, 2);
        @(negedge clk); #1;
        man_st = 1'b1; man_wr = 1'b1;
        start_a = 1'b1; num_blocks_a = 8'd5;
        @(negedge clk); #1;
        man_st = 1'b0; man_wr = 1'b0; start_a = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("stray_wait_rd_busy", int'(busy_a), 1);
        checkOutput("stray_wait_rd_stages", st_cnt, 0);
        checkOutput("stray_wait_rd_idx", int'(stage_sel_a) + int'(round_idx_a) + int'(blk_idx_a), 0);
        man_rd = 1'b1;
        @(negedge clk); #1;
        man_rd = 1'b0;
        auto_rd = 1'b1; auto_st = 1'b1; auto_wr = 1'b1;
        waitFinish(600, "stray");
        checkOutput("stray_reads", rd_cnt, 2);
        checkOutput("stray_sequence", seq_err, 0);

        // stage_done arriving exactly when the watchdog reaches TIMEOUT.
        clearMon(0);
        auto_st = 1'b0;
        doStart(0, 1);
        x_ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (stage_start_a) begin
                x_ok = 1;
                break;
            end
            @(negedge clk); #1;
        end
        checkOutput("edge_first_issue", x_ok, 1);
        repeat (255) @(negedge clk);
        @(negedge clk); #1;
        man_st = 1'b1;
        checkOutput("edge_busy_at_limit", int'(busy_a), 1);
        @(negedge clk); #1;
        man_st = 1'b0;
        auto_st = 1'b1;
        checkOutput("edge_no_err", int'(err_a), 0);
        checkOutput("edge_reissue", int'(stage_start_a), 1);
        waitFinish(400, "edge");
        checkOutput("edge_stages", st_cnt, 96);
        checkOutput("edge_sequence", seq_err, 0);
        checkOutput("edge_err_end", int'(err_a), 0);

        // stage_done withheld: err after the full watchdog window.
        clearMon(0);
        auto_st = 1'b0;
        doStart(0, 1);
        x_ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (stage_start_a) begin
                x_ok = 1;
                break;
            end
            @(negedge clk); #1;
        end
        checkOutput("hang_first_issue", x_ok, 1);
        repeat (256) @(negedge clk);
        #1;
        checkOutput("hang_err_before", int'(err_a), 0);
        checkOutput("hang_busy_before", int'(busy_a), 1);
        @(negedge clk); #1;
        checkOutput("hang_err", int'(err_a), 1);
        checkOutput("hang_busy", int'(busy_a), 0);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("hang_err_sticky", int'(err_a), 1);
        checkOutput("hang_no_pulses", st_cnt, 1);
        auto_st = 1'b1;
        applyStimulus(0, 0, 20, "clear_err");
        checkOutput("clear_err_value", int'(err_a), 0);
        checkOutput("clear_err_latency", fin_cyc - start_cyc, 0);

        // Asynchronous reset in WAIT_ST at round 5, stage 2.
        clearMon(0);
        doStart(0, 2);
        x_ok = 0;
        for (int i = 0; i < 400; i++) begin
            if (stage_start_a && (round_idx_a == 5'd5) && (stage_sel_a == 2'd2)) begin
                x_ok = 1;
                break;
            end
            @(negedge clk); #1;
        end
        checkOutput("midrst_reached", x_ok, 1);
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        pulses = read_file_a | stage_start_a | write_file_a | finish_a | busy_a | err_a;
        checkOutput("midrst_pulses", int'(pulses), 0);
        checkOutput("midrst_round", int'(round_idx_a), 0);
        checkOutput("midrst_stage", int'(stage_sel_a), 0);
        checkOutput("midrst_blk", int'(blk_idx_a), 0);
        @(negedge clk); #1;
        rst = 1'b1;
        applyStimulus(0, 1, 260, "post_rst");
        checkOutput("post_rst_reads", rd_cnt, 1);
        checkOutput("post_rst_sequence", seq_err, 0);
        checkOutput("post_rst_latency", fin_cyc - start_cyc, 197);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
